// File: rtl/peak_dbg_pkg.sv
// Shared types for the debug-side access-register (AR) master.
// The state enum, status bundle and AR port geometry all live here.
package peak_dbg_pkg;

   localparam int AR_NREGS  = 32;
   localparam int AR_ADDR_W = 5;
   localparam int AR_DATA_W = 32;
   localparam int AR_CNT_W  = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_CAP,
      ST_RD_RSP,
      ST_WR_WAIT,
      ST_WR_DO,
      ST_DONE
   } ar_state_t;

   typedef struct packed {
      logic valid;
      logic err;
   } sts_t;

endpackage

// File: rtl/peak_ar_master.sv
// Burst engine that walks the register file through its AR port while
// the core is halted, streaming read data out and write data in.
module peak_ar_master
   import peak_dbg_pkg::*;
#(
   parameter int ADDR_W = AR_ADDR_W,
   parameter int DATA_W = AR_DATA_W,
   parameter int CNT_W  = AR_CNT_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              HALTED,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [CNT_W-1:0]  CMD_COUNT,
   input  logic              WD_VALID,
   output logic              WD_READY,
   input  logic [DATA_W-1:0] WD_DATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_DATA,
   output logic              STS_VALID,
   output logic              STS_ERR,
   input  logic              ABORT,
   output logic              AR_EN,
   output logic              AR_WR,
   output logic [ADDR_W-1:0] AR_AD,
   output logic [DATA_W-1:0] AR_DI,
   input  logic [DATA_W-1:0] AR_DO
);

   localparam int SW    = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 2;
   localparam int NREGS = 2 ** ADDR_W;

   ar_state_t         r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic              r_cmd_ready;
   logic              r_ar_en;
   logic              r_ar_wr;
   logic [DATA_W-1:0] r_ar_di;
   logic              r_wd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   sts_t              r_sts;

   logic [SW-1:0]     w_end;
   logic              w_legal;
   logic              w_active;
   logic              w_abort;
   logic              w_kill;
   logic              w_cmd_hs;
   logic              w_rd_hs;
   logic              w_wd_hs;
   logic              w_last;
   logic              w_step;
   logic              w_go_done;
   logic              w_done_err;

   assign w_end   = SW'(CMD_ADDR) + SW'(CMD_COUNT);
   assign w_legal = HALTED
                  && (CMD_COUNT != '0)
                  && (w_end <= SW'(NREGS));

   assign w_active = (r_state == ST_RD_ADDR)
                  || (r_state == ST_RD_CAP)
                  || (r_state == ST_RD_RSP)
                  || (r_state == ST_WR_WAIT)
                  || (r_state == ST_WR_DO);

   assign w_abort = w_active && ABORT;
   assign w_kill  = w_active && (ABORT || !HALTED);

   // Abort masks the handshake-visible strobes in the same cycle.
   assign CMD_READY = r_cmd_ready;
   assign WD_READY  = r_wd_ready & ~w_abort;
   assign RSP_VALID = r_rsp_valid & ~w_abort;
   assign RSP_DATA  = r_rsp_data;
   assign STS_VALID = r_sts.valid;
   assign STS_ERR   = r_sts.err;
   assign AR_EN     = r_ar_en;
   assign AR_WR     = r_ar_wr & ~w_abort;
   assign AR_AD     = r_addr;
   assign AR_DI     = r_ar_di;

   assign w_cmd_hs = (r_state == ST_IDLE) && r_cmd_ready && CMD_VALID;
   assign w_rd_hs  = (r_state == ST_RD_RSP) && RSP_VALID && RSP_READY;
   assign w_wd_hs  = (r_state == ST_WR_WAIT) && WD_READY && WD_VALID;
   assign w_last   = (r_cnt == CNT_W'(1));
   assign w_step   = w_rd_hs || (r_state == ST_WR_DO);

   always_comb begin
      w_go_done  = 1'b0;
      w_done_err = r_err;
      if (w_cmd_hs && !w_legal) begin
         w_go_done  = 1'b1;
         w_done_err = 1'b1;
      end else if (w_kill) begin
         w_go_done  = 1'b1;
         w_done_err = 1'b1;
      end else if (w_step && w_last) begin
         w_go_done  = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_ar_en     <= 1'b0;
         r_ar_wr     <= 1'b0;
         r_ar_di     <= '0;
         r_wd_ready  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_sts       <= '0;
      end else begin
         r_sts <= '0;
         if (w_cmd_hs) begin
            r_addr <= CMD_ADDR;
            r_cnt  <= CMD_COUNT;
         end else if (w_step) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
         end
         if (w_go_done) begin
            r_state     <= ST_DONE;
            r_cmd_ready <= 1'b0;
            r_ar_en     <= 1'b0;
            r_ar_wr     <= 1'b0;
            r_wd_ready  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= w_done_err;
            r_sts       <= '{valid: 1'b1, err: w_done_err};
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  r_cmd_ready <= 1'b1;
                  if (w_cmd_hs) begin
                     r_cmd_ready <= 1'b0;
                     r_err       <= 1'b0;
                     r_ar_en     <= 1'b1;
                     if (CMD_WRITE) begin
                        r_state    <= ST_WR_WAIT;
                        r_wd_ready <= 1'b1;
                     end else begin
                        r_state <= ST_RD_ADDR;
                     end
                  end
               end
               ST_RD_ADDR: begin
                  r_state <= ST_RD_CAP;
               end
               ST_RD_CAP: begin
                  r_rsp_data  <= AR_DO;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RD_RSP;
               end
               ST_RD_RSP: begin
                  if (w_rd_hs) begin
                     r_rsp_valid <= 1'b0;
                     r_state     <= ST_RD_ADDR;
                  end
               end
               ST_WR_WAIT: begin
                  if (w_wd_hs) begin
                     r_ar_di    <= WD_DATA;
                     r_wd_ready <= 1'b0;
                     // x0 is hardwired: consume the word, skip the strobe
                     r_ar_wr    <= (r_addr != '0);
                     r_state    <= ST_WR_DO;
                  end
               end
               ST_WR_DO: begin
                  r_ar_wr    <= 1'b0;
                  r_wd_ready <= 1'b1;
                  r_state    <= ST_WR_WAIT;
               end
               ST_DONE: begin
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_peak_ar_master.sv
// Directed bench for peak_ar_master with a 1-cycle-latency register
// file model hanging off the AR port.
module tb_peak_ar_master;
   import peak_dbg_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        HALTED = 1'b1;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic        CMD_WRITE = 1'b0;
   logic [4:0]  CMD_ADDR = '0;
   logic [5:0]  CMD_COUNT = '0;
   logic        WD_VALID = 1'b0;
   logic        WD_READY;
   logic [31:0] WD_DATA = '0;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b0;
   logic [31:0] RSP_DATA;
   logic        STS_VALID;
   logic        STS_ERR;
   logic        ABORT = 1'b0;
   logic        AR_EN;
   logic        AR_WR;
   logic [4:0]  AR_AD;
   logic [31:0] AR_DI;
   logic [31:0] AR_DO = '0;

   int checks = 0;
   int fails = 0;

   peak_ar_master dut (
      .CLK(CLK), .RST_N(RST_N), .HALTED(HALTED),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR),
      .CMD_COUNT(CMD_COUNT),
      .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_DATA(RSP_DATA),
      .STS_VALID(STS_VALID), .STS_ERR(STS_ERR), .ABORT(ABORT),
      .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD),
      .AR_DI(AR_DI), .AR_DO(AR_DO)
   );

   always #5 CLK = ~CLK;

   logic [31:0] regs [32];
   logic        pl_we = 1'b0;
   logic [4:0]  pl_a = '0;
   logic [31:0] pl_d = '0;

   always @(posedge CLK) begin
      if (pl_we) regs[pl_a] <= pl_d;
      else if (AR_EN && AR_WR && AR_AD != 5'd0) regs[AR_AD] <= AR_DI;
      AR_DO <= (AR_AD == 5'd0) ? 32'h0 : regs[AR_AD];
   end

   int          sts_cnt = 0;
   int          wr_cnt = 0;
   int          aren_cnt = 0;
   int          rspv_cnt = 0;
   logic [4:0]  wr_ad_q[$];
   logic [31:0] wr_di_q[$];
   logic [31:0] rq[$];
   logic [4:0]  aq[$];

   always @(negedge CLK) begin
      if (STS_VALID) sts_cnt <= sts_cnt + 1;
      if (AR_EN) aren_cnt <= aren_cnt + 1;
      if (RSP_VALID) rspv_cnt <= rspv_cnt + 1;
      if (AR_WR) begin
         wr_cnt <= wr_cnt + 1;
         wr_ad_q.push_back(AR_AD);
         wr_di_q.push_back(AR_DI);
      end
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pl(input logic [4:0] a, input logic [31:0] d);
      pl_we = 1'b1;
      pl_a = a;
      pl_d = d;
      tick();
      pl_we = 1'b0;
   endtask

   task automatic send_cmd(input logic wr, input logic [4:0] a,
                           input logic [5:0] c, output bit ok);
      int i = 0;
      ok = 1'b0;
      CMD_VALID = 1'b1;
      CMD_WRITE = wr;
      CMD_ADDR = a;
      CMD_COUNT = c;
      while (!ok && i < 20) begin
         if (CMD_READY) ok = 1'b1;
         tick();
         i++;
      end
      CMD_VALID = 1'b0;
   endtask

   task automatic wd_send(input logic [31:0] d, input int gap,
                          output bit ok);
      int i = 0;
      ok = 1'b0;
      repeat (gap) tick();
      WD_VALID = 1'b1;
      WD_DATA = d;
      while (!ok && i < 20) begin
         if (WD_READY) ok = 1'b1;
         tick();
         i++;
      end
      WD_VALID = 1'b0;
   endtask

   task automatic wait_sts(input int s0, input int maxc, output bit ok);
      int i = 0;
      while (sts_cnt == s0 && i < maxc) begin
         tick();
         i++;
      end
      ok = (sts_cnt != s0);
   endtask

   task automatic wait_rspv(input int maxc);
      int i = 0;
      while (!RSP_VALID && i < maxc) begin
         tick();
         i++;
      end
   endtask

   task automatic collect(input int s0, input int maxc, output bit ok);
      int i = 0;
      while (sts_cnt == s0 && i < maxc) begin
         if (RSP_VALID && RSP_READY) begin
            rq.push_back(RSP_DATA);
            aq.push_back(AR_AD);
         end
         tick();
         i++;
      end
      ok = (sts_cnt != s0);
   endtask

   task automatic do_read(input logic [4:0] a, input logic [5:0] c,
                          output bit ok);
      int s;
      bit okc;
      RSP_READY = 1'b1;
      rq.delete();
      aq.delete();
      s = sts_cnt;
      send_cmd(1'b0, a, c, okc);
      chk("rd_cmd_hs", 32'(okc), 1);
      collect(s, 80, ok);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int s0;
      int w0;
      int e0;
      int r0;
      logic [4:0] il_a [3];
      logic [5:0] il_c [3];
      logic       il_h [3];
      il_a = '{5'd31, 5'd5, 5'd1};
      il_c = '{6'd2, 6'd0, 6'd1};
      il_h = '{1'b1, 1'b1, 1'b0};

      pl(5'd1, 32'h11);
      pl(5'd2, 32'h22);
      pl(5'd3, 32'h33);
      pl(5'd4, 32'h44);
      chk("rst_cmd_ready", 32'(CMD_READY), 0);
      chk("rst_outs", 32'({AR_EN, AR_WR, WD_READY, RSP_VALID,
                           STS_VALID, STS_ERR}), 0);
      chk("rst_ar_ad", 32'(AR_AD), 0);
      RST_N = 1'b1;
      tick();
      chk("cmd_ready_rise", 32'(CMD_READY), 1);

      // Basic 3-word read
      do_read(5'd1, 6'd3, ok);
      chk("rd1_sts", 32'(ok), 1);
      chk("rd1_err", 32'(STS_ERR), 0);
      chk("rd1_n", rq.size(), 3);
      chk("rd1_d0", rq[0], 32'h11);
      chk("rd1_d1", rq[1], 32'h22);
      chk("rd1_d2", rq[2], 32'h33);
      chk("rd1_a0", 32'(aq[0]), 1);
      chk("rd1_a1", 32'(aq[1]), 2);
      chk("rd1_a2", 32'(aq[2]), 3);
      chk("rd1_aren_done", 32'(AR_EN), 0);
      tick();
      chk("rd1_aren_idle", 32'(AR_EN), 0);

      // Read from x0 with a stalled consumer
      RSP_READY = 1'b0;
      rq.delete();
      aq.delete();
      s0 = sts_cnt;
      send_cmd(1'b0, 5'd0, 6'd2, ok);
      chk("rd0_cmd_hs", 32'(ok), 1);
      wait_rspv(10);
      chk("rd0_valid", 32'(RSP_VALID), 1);
      for (int k = 0; k < 4; k++) begin
         chk("rd0_hold_v", 32'(RSP_VALID), 1);
         chk("rd0_hold_d", RSP_DATA, 32'h0);
         chk("rd0_hold_ad", 32'(AR_AD), 0);
         tick();
      end
      RSP_READY = 1'b1;
      collect(s0, 40, ok);
      chk("rd0_sts", 32'(ok), 1);
      chk("rd0_err", 32'(STS_ERR), 0);
      chk("rd0_n", rq.size(), 2);
      chk("rd0_d0", rq[0], 32'h0);
      chk("rd0_d1", rq[1], 32'h11);
      chk("rd0_a1", 32'(aq[1]), 1);

      // Write x30,x31 with a data gap
      tick();
      w0 = wr_cnt;
      wr_ad_q.delete();
      wr_di_q.delete();
      s0 = sts_cnt;
      send_cmd(1'b1, 5'd30, 6'd2, ok);
      chk("wr_cmd_hs", 32'(ok), 1);
      wd_send(32'hDEADBEEF, 0, ok);
      chk("wr_wd0_hs", 32'(ok), 1);
      wd_send(32'h12345678, 2, ok);
      chk("wr_wd1_hs", 32'(ok), 1);
      wait_sts(s0, 10, ok);
      chk("wr_sts", 32'(ok), 1);
      chk("wr_err", 32'(STS_ERR), 0);
      chk("wr_pulses", 32'(wr_cnt - w0), 2);
      chk("wr_ad0", 32'(wr_ad_q[0]), 30);
      chk("wr_ad1", 32'(wr_ad_q[1]), 31);
      chk("wr_di0", wr_di_q[0], 32'hDEADBEEF);
      chk("wr_di1", wr_di_q[1], 32'h12345678);
      tick();
      do_read(5'd30, 6'd2, ok);
      chk("wrb_sts", 32'(ok), 1);
      chk("wrb_d0", rq[0], 32'hDEADBEEF);
      chk("wrb_d1", rq[1], 32'h12345678);

      // Write to x0 is consumed but never strobed
      tick();
      w0 = wr_cnt;
      s0 = sts_cnt;
      send_cmd(1'b1, 5'd0, 6'd1, ok);
      chk("wx0_cmd_hs", 32'(ok), 1);
      wd_send(32'hFFFFFFFF, 0, ok);
      chk("wx0_wd_hs", 32'(ok), 1);
      wait_sts(s0, 10, ok);
      chk("wx0_sts", 32'(ok), 1);
      chk("wx0_err", 32'(STS_ERR), 0);
      chk("wx0_no_wr", 32'(wr_cnt - w0), 0);
      tick();
      do_read(5'd0, 6'd1, ok);
      chk("wx0_rb_sts", 32'(ok), 1);
      chk("wx0_rb", rq[0], 32'h0);

      // Illegal commands
      for (int k = 0; k < 3; k++) begin
         tick();
         HALTED = il_h[k];
         e0 = aren_cnt;
         s0 = sts_cnt;
         send_cmd(1'b0, il_a[k], il_c[k], ok);
         chk("ill_cmd_hs", 32'(ok), 1);
         wait_sts(s0, 2, ok);
         chk("ill_sts", 32'(ok), 1);
         chk("ill_err", 32'(STS_ERR), 1);
         chk("ill_no_aren", 32'(aren_cnt - e0), 0);
         HALTED = 1'b1;
      end

      // Abort while idle has no effect
      tick();
      tick();
      s0 = sts_cnt;
      ABORT = 1'b1;
      tick();
      tick();
      ABORT = 1'b0;
      chk("ab_idle_sts", 32'(sts_cnt - s0), 0);
      chk("ab_idle_rdy", 32'(CMD_READY), 1);

      // Abort after two words of a four-word read
      RSP_READY = 1'b1;
      rq.delete();
      s0 = sts_cnt;
      send_cmd(1'b0, 5'd1, 6'd4, ok);
      chk("ab_cmd_hs", 32'(ok), 1);
      for (int i = 0; i < 40 && rq.size() < 2; i++) begin
         if (RSP_VALID && RSP_READY) rq.push_back(RSP_DATA);
         tick();
      end
      RSP_READY = 1'b0;
      wait_rspv(10);
      ABORT = 1'b1;
      #1;
      chk("ab_rspv_mask", 32'(RSP_VALID), 0);
      tick();
      ABORT = 1'b0;
      chk("ab_sts", 32'(sts_cnt - s0), 1);
      chk("ab_err", 32'(STS_ERR), 1);
      r0 = rspv_cnt;
      RSP_READY = 1'b1;
      repeat (5) tick();
      chk("ab_no_rspv", 32'(rspv_cnt - r0), 0);
      chk("ab_n", rq.size(), 2);
      chk("ab_d1", rq[1], 32'h22);

      // Halt drops while a read word is pending
      RSP_READY = 1'b0;
      s0 = sts_cnt;
      send_cmd(1'b0, 5'd1, 6'd3, ok);
      chk("hd_cmd_hs", 32'(ok), 1);
      wait_rspv(10);
      HALTED = 1'b0;
      tick();
      chk("hd_sts", 32'(sts_cnt - s0), 1);
      chk("hd_err", 32'(STS_ERR), 1);
      HALTED = 1'b1;
      tick();

      // Reset in the middle of a write burst
      tick();
      s0 = sts_cnt;
      send_cmd(1'b1, 5'd10, 6'd3, ok);
      chk("rw_cmd_hs", 32'(ok), 1);
      wd_send(32'hA5A5A5A5, 0, ok);
      chk("rw_wd_hs", 32'(ok), 1);
      chk("rw_arwr_pre", 32'(AR_WR), 1);
      RST_N = 1'b0;
      #1;
      chk("rw_aren_async", 32'(AR_EN), 0);
      chk("rw_arwr_async", 32'(AR_WR), 0);
      chk("rw_wdr_async", 32'(WD_READY), 0);
      repeat (3) tick();
      RST_N = 1'b1;
      tick();
      tick();
      chk("rw_no_sts", 32'(sts_cnt - s0), 0);
      chk("rw_cmd_ready", 32'(CMD_READY), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/peak_ar_master.md
Name: peak_ar_master

Overview:
- Debug-side initiator for the register file's access-register (AR) port. It drives AR_EN/AR_WR/AR_AD/AR_DI and captures AR_DO.
- Turns burst commands from the debug module (start register, count, direction) into per-register AR cycles.
- Streams read data out and write data in over valid/ready handshakes, then reports a completion status.
- Sits between the debug module and peak_reg. It is only legal while the core is halted, because AR_EN overrides core writeback and RS1 addressing.

Parameters:
- ADDR_W, 5, AR register address width (task-0 registers x0..x31)
- DATA_W, 32, register data width
- CNT_W, 6, burst count width (legal count 1..32)

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- HALTED  in  1  core halted; AR access permitted only when 1
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_WRITE  in  1  1=write burst, 0=read burst
- CMD_ADDR  in  ADDR_W  first register
- CMD_COUNT  in  CNT_W  number of registers
- WD_VALID  in  1  write data valid
- WD_READY  out  1  write data consumed when VALID&READY
- WD_DATA  in  DATA_W  write data
- RSP_VALID  out  1  read data valid
- RSP_READY  in  1  read data consumed
- RSP_DATA  out  DATA_W  read data
- STS_VALID  out  1  one-cycle completion pulse
- STS_ERR  out  1  error flag, qualified by STS_VALID
- ABORT  in  1  terminate current burst
- AR_EN  out  1  AR port enable to register file
- AR_WR  out  1  AR write strobe
- AR_AD  out  ADDR_W  AR address
- AR_DI  out  DATA_W  AR write data
- AR_DO  in  DATA_W  AR read data (valid the cycle after address; x0 reads 0)

Behaviour:
- Reset (async, RST_N=0):
  - State is IDLE.
  - All outputs are 0, including CMD_READY.
  - CMD_READY rises in the first clock after reset release.
- States: IDLE, RD_ADDR, RD_CAP, RD_RSP, WR_WAIT, WR_DO, DONE.
- IDLE:
  - CMD_READY=1 and AR_EN=0.
  - On accept, latch addr/count/dir.
  - A command is illegal if count==0, addr+count>32, or HALTED=0. An illegal command moves to DONE with err=1 and issues no AR cycle.
  - A legal read goes to RD_ADDR; a legal write goes to WR_WAIT.
- AR_EN is held 1 from the first active state through the last AR cycle, and is 0 in IDLE and DONE.
- AR_AD always equals the current address register.
- Read path:
  - RD_ADDR presents the address (AR_WR=0), then goes to RD_CAP.
  - RD_CAP samples AR_DO into RSP_DATA (1-cycle register-file latency), sets RSP_VALID, then goes to RD_RSP.
  - RD_RSP holds RSP_VALID/RSP_DATA stable until RSP_READY. On handshake: decrement count, increment address, then go to RD_ADDR if remaining >0, else DONE.
  - One read is outstanding at a time; throughput is at most one word per 3 cycles.
- Write path:
  - WR_WAIT asserts WD_READY=1.
  - On handshake, latch WD_DATA into AR_DI and go to WR_DO.
  - WR_DO pulses AR_WR=1 for exactly one cycle; AR_WR=0 if the address is 0, so x0 writes are discarded but the data is still consumed. Then decrement count, increment address, and go to WR_WAIT or DONE.
- Address increment is modulo 32. The legality check guarantees the address never wraps within a burst.
- DONE: STS_VALID=1 for one cycle with STS_ERR, then IDLE.
- HALTED falls mid-burst: finish any in-flight AR_WR cycle, then go to DONE with err=1. Remaining words are neither issued nor handshaken.
- ABORT (sampled every cycle in non-IDLE states):
  - Next state is DONE with err=1, except an already-set err is retained.
  - AR_WR is forced 0 that cycle, RSP_VALID is cleared, and WD_READY is cleared.
  - ABORT in IDLE is ignored.
  - ABORT coinciding with the final handshake still reports err=1.
- Reset mid-burst: all outputs go to 0 immediately, with no status pulse.

Decomposition:
- Shared package peak_dbg_pkg:
  - ar_state_t enum (the 7 states)
  - AR_NREGS=32
  - AR_ADDR_W, AR_DATA_W, AR_CNT_W
  - the sts_t {valid, err} struct
- Single module; no sub-module. A 1-deep response register suffices with one outstanding read.

Test Plan:
- Preload x1..x3 = 0x11,0x22,0x33; read cmd addr=1,count=3, RSP_READY=1 -> RSP_DATA 0x11,0x22,0x33; AR_AD sequence 1,2,3; STS_VALID with ERR=0; AR_EN low afterward.
- Read addr=0,count=2 with RSP_READY low for 4 cycles on the first word -> RSP_DATA held at 0x0 and stable throughout; AR_AD stays 0 until handshake; second word is x1.
- Write addr=30,count=2, WD_DATA 0xDEADBEEF,0x12345678 with a 2-cycle WD_VALID gap -> exactly two 1-cycle AR_WR pulses at AR_AD 30,31; readback matches; ERR=0.
- Write addr=0,count=1, data 0xFFFFFFFF -> WD handshake occurs, AR_WR stays 0, x0 reads 0, ERR=0.
- Illegal commands: addr=31,count=2; count=0; HALTED=0 -> each gives CMD handshake, then STS_VALID with ERR=1 within 2 cycles and no AR_EN assertion.
- ABORT mid 4-word read after word 2, and RST_N low mid write burst -> abort gives STS ERR=1 and no further RSP_VALID; reset drops AR_EN/AR_WR asynchronously the same cycle and gives no STS pulse.
